// File: rtl/neopixel_pattern_sequencer_pkg.sv
// Shared definitions for the neopixel pattern sequencer: pattern modes,
// GRB pixel word layout and sequencer FSM states.
package neopixel_pkg;

    // Pattern mode encodings
    localparam logic [1:0] MODE_OFF   = 2'd0;
    localparam logic [1:0] MODE_SOLID = 2'd1;
    localparam logic [1:0] MODE_CHASE = 2'd2;
    localparam logic [1:0] MODE_WIPE  = 2'd3;

    // Colour word layout {G, R, B}
    localparam int unsigned PIX_G_MSB = 23;
    localparam int unsigned PIX_G_LSB = 16;
    localparam int unsigned PIX_R_MSB = 15;
    localparam int unsigned PIX_R_LSB = 8;
    localparam int unsigned PIX_B_MSB = 7;
    localparam int unsigned PIX_B_LSB = 0;

    // Sequencer FSM states
    typedef enum logic [1:0] {
        StIdle  = 2'd0,
        StWrite = 2'd1,
        StDone  = 2'd2
    } state_e;

endpackage

// File: rtl/neopixel_pattern_sequencer_if.sv
// Control-write port of the neopixel driver: the sequencer is the master,
// the driver is the slave and back-pressures through ready.
interface neopixel_ctrl_if;

    logic        write_en;
    logic [31:0] address;
    logic [31:0] write_data;
    logic        ready;

    modport master (
        output write_en,
        output address,
        output write_data,
        input  ready
    );

    modport slave (
        input  write_en,
        input  address,
        input  write_data,
        output ready
    );

endinterface

// File: rtl/neopixel_pattern_sequencer_frame_timer.sv
// Frame rate timer: free-running tick counter, single-deep pending request
// and a one-cycle overrun pulse for every tick lost while a request waits.
module neopixel_frame_timer #(
    parameter logic [31:0] C_RATE = 32'd33000000
) (
    input  logic clock,
    input  logic reset,
    input  logic i_enable,
    input  logic i_start,
    output logic o_pending,
    output logic o_overrun
);

    logic [31:0] r_count;
    logic        r_pending;
    logic        r_overrun;
    logic        w_tick;

    assign w_tick    = i_enable && (r_count == (C_RATE - 32'd1));
    assign o_pending = r_pending;
    assign o_overrun = r_overrun;

    // Tick counter, pending flag and overrun pulse
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_count   <= 32'd0;
            r_pending <= 1'b0;
            r_overrun <= 1'b0;
        end else if (!i_enable) begin
            r_count   <= 32'd0;
            r_pending <= 1'b0;
            r_overrun <= 1'b0;
        end else begin
            r_count   <= w_tick ? 32'd0 : r_count + 32'd1;
            // A tick landing on the start cycle re-arms pending rather than being lost
            r_overrun <= w_tick && r_pending && !i_start;
            if (w_tick) begin
                r_pending <= 1'b1;
            end else if (i_start) begin
                r_pending <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/neopixel_pattern_sequencer.sv
// Autonomous frame sequencer: on every pending frame request it streams
// C_PIXELS pattern words into the neopixel driver control port.
module neopixel_pattern_sequencer
    import neopixel_pkg::*;
#(
    parameter int unsigned  C_PIXELS = 12,
    parameter logic [31:0]  C_RATE   = 32'd33000000,
    localparam int unsigned C_HW     = $clog2(C_PIXELS)
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              enable,
    input  logic [1:0]        mode,
    input  logic [23:0]       color,
    neopixel_ctrl_if.master   bus,
    output logic              frame_done,
    output logic              overrun,
    output logic [C_HW-1:0]   head
);

    localparam logic [C_HW-1:0] C_LAST = C_HW'(C_PIXELS - 1);

    state_e          r_state;
    logic [C_HW-1:0] r_p;
    logic [C_HW-1:0] r_head;
    logic [1:0]      r_mode;
    logic [23:0]     r_color;
    logic            r_wen;
    logic [31:0]     r_addr;
    logic [31:0]     r_data;
    logic            r_done;

    logic            w_pending;
    logic            w_start;
    logic            w_accept;
    logic [C_HW-1:0] w_p_next;

    // Pixel word for position p given the frame's mode, colour and head
    function automatic logic [31:0] f_pattern(
        input logic [1:0]      f_mode,
        input logic [23:0]     f_color,
        input logic [C_HW-1:0] f_p,
        input logic [C_HW-1:0] f_head
    );
        logic lit;
        lit = 1'b0;
        case (f_mode)
            MODE_OFF:   lit = 1'b0;
            MODE_SOLID: lit = 1'b1;
            MODE_CHASE: lit = (f_p == f_head);
            MODE_WIPE:  lit = (f_p <= f_head);
            default:    lit = 1'b0;
        endcase
        return lit ? {8'h00, f_color[PIX_G_MSB:PIX_G_LSB], f_color[PIX_R_MSB:PIX_R_LSB],
                      f_color[PIX_B_MSB:PIX_B_LSB]}
                   : 32'h0;
    endfunction

    assign w_start  = (r_state == StIdle) && w_pending && enable;
    assign w_accept = r_wen && bus.ready;
    assign w_p_next = r_p + 1'b1;

    neopixel_frame_timer #(
        .C_RATE (C_RATE)
    ) u_timer (
        .clock     (clock),
        .reset     (reset),
        .i_enable  (enable),
        .i_start   (w_start),
        .o_pending (w_pending),
        .o_overrun (overrun)
    );

    // Frame FSM with registered write port, frame_done and head
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_state <= StIdle;
            r_p     <= '0;
            r_head  <= '0;
            r_mode  <= MODE_OFF;
            r_color <= 24'h0;
            r_wen   <= 1'b0;
            r_addr  <= 32'h0;
            r_data  <= 32'h0;
            r_done  <= 1'b0;
        end else begin
            r_done <= 1'b0;
            unique case (r_state)
                StIdle: begin
                    if (w_start) begin
                        // Shadow mode/colour so mid-frame changes wait for the next frame
                        r_mode  <= mode;
                        r_color <= color;
                        r_p     <= '0;
                        r_wen   <= 1'b1;
                        r_addr  <= 32'h0;
                        r_data  <= f_pattern(mode, color, '0, r_head);
                        r_state <= StWrite;
                    end
                end
                StWrite: begin
                    if (w_accept) begin
                        if (r_p == C_LAST) begin
                            r_wen   <= 1'b0;
                            r_done  <= 1'b1;
                            r_state <= StDone;
                        end else begin
                            r_p    <= w_p_next;
                            r_addr <= 32'(w_p_next);
                            r_data <= f_pattern(r_mode, r_color, w_p_next, r_head);
                        end
                    end
                end
                StDone: begin
                    r_head  <= (r_head == C_LAST) ? '0 : r_head + 1'b1;
                    r_state <= StIdle;
                end
                default: r_state <= StIdle;
            endcase
        end
    end

    assign bus.write_en   = r_wen;
    assign bus.address    = r_addr;
    assign bus.write_data = r_data;
    assign frame_done     = r_done;
    assign head           = r_head;

endmodule

// File: tb/tb_neopixel_pattern_sequencer.sv
// Scoreboard bench: stimulus pushes whole expected frames from a pattern
// model; a negedge monitor pops and compares every accepted write.
module tb_neopixel_pattern_sequencer;

    localparam int          NP   = 4;
    localparam logic [31:0] RATE = 32'd20;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        enable = 1'b0;
    logic [1:0]  mode = 2'd0;
    logic [23:0] color = 24'h0;
    logic        frame_done;
    logic        overrun;
    logic [1:0]  head;

    neopixel_ctrl_if bus ();

    neopixel_pattern_sequencer #(
        .C_PIXELS (NP),
        .C_RATE   (RATE)
    ) dut (
        .clock      (clock),
        .reset      (reset),
        .enable     (enable),
        .mode       (mode),
        .color      (color),
        .bus        (bus),
        .frame_done (frame_done),
        .overrun    (overrun),
        .head       (head)
    );

    always #5 clock = ~clock;

    typedef struct {
        int          addr;
        logic [31:0] data;
        int          hd;
    } exp_t;

    exp_t q[$];
    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;
    int   head_m = 0;
    int   frames_done = 0;
    int   overruns = 0;
    int   last_accept_cyc = -100;
    int   last_accept_addr = -1;
    int   last_done_cyc = -100;
    int   prev_start = -1;
    int   start_exp = -1;
    bit   period_chk = 0;
    bit   quick_chk = 0;
    bit   prev_stall = 0;
    logic [31:0] prev_addr = 32'h0;
    logic [31:0] prev_data = 32'h0;
    int   ready_mode = 0;
    bit   ready_fixed = 1;

    always @(posedge clock) cyc <= cyc + 1;

    task automatic chk(input string name, input longint act, input longint exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Reference pixel value straight from the pattern rules
    function automatic logic [31:0] model_pixel(int m, logic [23:0] c, int p, int h);
        bit lit;
        case (m)
            1:       lit = 1;
            2:       lit = (p == h);
            3:       lit = (p <= h);
            default: lit = 0;
        endcase
        return lit ? {8'h00, c} : 32'h0;
    endfunction

    task automatic push_frame(input int m, input logic [23:0] c);
        exp_t e;
        for (int p = 0; p < NP; p++) begin
            e.addr = p;
            e.data = model_pixel(m, c, p, head_m);
            e.hd   = head_m;
            q.push_back(e);
        end
        head_m = (head_m + 1) % NP;
    endtask

    task automatic wait_frames(input int target, input int budget);
        int n;
        n = 0;
        while (frames_done < target && n < budget) begin
            @(posedge clock);
            #1;
            n++;
        end
        if (frames_done < target) begin
            checks++;
            errors++;
            $display("FAIL frame_timeout: got %0d frames expected %0d", frames_done, target);
        end
        chk("queue_drained", longint'(q.size()), 0);
    endtask

    task automatic wait_addr(input int a, input int budget);
        int n;
        n = 0;
        while (n < budget) begin
            @(negedge clock);
            if (bus.write_en && bus.address == 32'(a)) break;
            n++;
        end
        if (n >= budget) begin
            checks++;
            errors++;
            $display("FAIL addr_timeout: address %0d never presented", a);
        end
    endtask

    // ready driver
    initial begin
        bus.ready = 1'b0;
        forever begin
            @(posedge clock);
            #1;
            case (ready_mode)
                1:       bus.ready = (cyc % 4 == 0) || (cyc % 4 == 3);
                2:       bus.ready = ($urandom_range(7) != 0);
                default: bus.ready = ready_fixed;
            endcase
        end
    end

    // Monitor: compares every accepted write and frame_done pulse
    always @(negedge clock) begin
        exp_t e;
        if (reset) begin
            prev_stall = 0;
        end else begin
            if (prev_stall) begin
                chk("hold_wen", longint'(bus.write_en), 1);
                chk("hold_addr", longint'(bus.address), longint'(prev_addr));
                chk("hold_data", longint'(bus.write_data), longint'(prev_data));
            end
            prev_stall = bus.write_en && !bus.ready;
            prev_addr  = bus.address;
            prev_data  = bus.write_data;
            if (bus.write_en && bus.ready) begin
                if (q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_write: addr %0d data %h, none expected",
                             bus.address, bus.write_data);
                end else begin
                    e = q.pop_front();
                    chk("addr", longint'(bus.address), longint'(e.addr));
                    chk("data", longint'(bus.write_data), longint'(e.data));
                    chk("head", longint'(head), longint'(e.hd));
                end
                if (bus.address == 32'h0) begin
                    if (period_chk && prev_start >= 0)
                        chk("frame_period", longint'(cyc - prev_start), longint'(RATE));
                    if (quick_chk) begin
                        chk("pending_service", longint'(cyc - last_done_cyc), 2);
                        quick_chk = 0;
                    end
                    if (start_exp >= 0) begin
                        chk("start_after_reset", longint'(cyc), longint'(start_exp));
                        start_exp = -1;
                    end
                    prev_start = cyc;
                end
                last_accept_cyc  = cyc;
                last_accept_addr = int'(bus.address);
            end
            if (frame_done) begin
                chk("done_after_last", longint'(cyc - last_accept_cyc), 1);
                chk("done_last_addr", longint'(last_accept_addr), NP - 1);
                frames_done++;
                last_done_cyc = cyc;
            end
            if (overrun) overruns++;
        end
    end

    initial begin
        int fd;
        int ov0;
        repeat (3) @(posedge clock);
        #1;
        chk("rst_wen", longint'(bus.write_en), 0);
        chk("rst_addr", longint'(bus.address), 0);
        chk("rst_data", longint'(bus.write_data), 0);
        chk("rst_done", longint'(frame_done), 0);
        chk("rst_overrun", longint'(overrun), 0);
        chk("rst_head", longint'(head), 0);
        reset = 1'b0;

        // Solid frames, ready tied high, fixed frame period
        mode = 2'd1;
        color = 24'h00FF00;
        ready_fixed = 1;
        period_chk = 1;
        prev_start = -1;
        for (int i = 0; i < 4; i++) push_frame(1, 24'h00FF00);
        enable = 1'b1;
        wait_frames(frames_done + 4, 4 * RATE + 40);

        // Chase, head wraps 3 -> 0
        mode = 2'd2;
        color = 24'hFF0000;
        for (int i = 0; i < 5; i++) push_frame(2, 24'hFF0000);
        wait_frames(frames_done + 5, 5 * RATE + 20);

        // Wipe with ready toggling 1-0-0-1
        period_chk = 0;
        mode = 2'd3;
        color = 24'($urandom);
        ready_mode = 1;
        for (int i = 0; i < 3; i++) push_frame(3, color);
        wait_frames(frames_done + 3, 3 * RATE + 40);

        // Random modes/colours with random back-pressure
        ready_mode = 2;
        for (int i = 0; i < 6; i++) begin
            mode = 2'($urandom_range(3));
            color = 24'($urandom);
            push_frame(int'(mode), color);
            wait_frames(frames_done + 1, 2 * RATE + 20);
        end

        // Long stall: one lost tick, pending serviced right after DONE
        ready_mode = 0;
        ready_fixed = 1;
        mode = 2'd1;
        color = 24'($urandom);
        ov0 = overruns;
        fd = frames_done;
        for (int i = 0; i < 3; i++) push_frame(1, color);
        wait_addr(1, 2 * RATE + 10);
        ready_fixed = 0;
        repeat (45) @(posedge clock);
        #1;
        ready_fixed = 1;
        quick_chk = 1;
        wait_frames(fd + 3, 4 * RATE + 20);
        chk("overrun_pulses", longint'(overruns - ov0), 1);

        // enable dropped mid-frame: frame completes, then silence
        push_frame(1, color);
        wait_addr(1, 2 * RATE + 10);
        enable = 1'b0;
        wait_frames(frames_done + 1, RATE);
        fd = frames_done;
        repeat (60) @(posedge clock);
        #1;
        chk("no_frames_disabled", longint'(frames_done), longint'(fd));
        mode = 2'd2;
        push_frame(2, color);
        push_frame(2, color);
        enable = 1'b1;
        wait_frames(fd + 2, 3 * RATE + 20);

        // Asynchronous reset during WRITE at p=2
        push_frame(2, color);
        wait_addr(2, 2 * RATE + 10);
        #1;
        reset = 1'b1;
        #1;
        chk("async_rst_wen", longint'(bus.write_en), 0);
        chk("async_rst_head", longint'(head), 0);
        chk("async_rst_addr", longint'(bus.address), 0);
        q.delete();
        head_m = 0;
        repeat (3) @(posedge clock);
        #1;
        reset = 1'b0;
        start_exp = cyc + 21;
        push_frame(2, color);
        wait_frames(frames_done + 1, 2 * RATE + 20);
        chk("start_after_reset_seen", longint'(start_exp), -1);
        chk("total_overruns", longint'(overruns), 1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
